// File: rtl/fetch_decode_stage.sv
// Fetch stage with IF/ID pipeline register.
// Holds the PC, issues instruction-memory reads, registers each fetched word
// together with its PC, and presents the decoded fields to the control unit.
// A single-entry hold buffer catches a word that arrives while the
// downstream stage is stalled; a flush drops all in-flight work and redirects
// fetch to FlushPC.
module fetch_decode_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter logic [XLEN-1:0] PC_STEP  = XLEN'(4)
) (
    input  logic            CLK,
    input  logic            RST,
    output logic            IMemReq,
    output logic [XLEN-1:0] IMemAddr,
    input  logic [31:0]     IMemRdata,
    input  logic            IMemAck,
    input  logic            Stall,
    input  logic            Flush,
    input  logic [XLEN-1:0] FlushPC,
    output logic            IDValid,
    output logic [XLEN-1:0] IDPC,
    output logic [6:0]      Opecode,
    output logic [2:0]      ALUOp,
    output logic [6:0]      funct,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] ImmI,
    output logic [XLEN-1:0] ImmS,
    output logic [4:0]      Shamt
);

    // FETCH: a read is outstanding at PC. HOLD: a fetched word sits in the buffer.
    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [XLEN-1:0] pc_r, pc_s;
    logic [XLEN-1:0] buf_pc_r, buf_pc_s;
    logic [31:0]     buf_word_r, buf_word_s;
    logic            id_valid_r, id_valid_s;
    logic [XLEN-1:0] id_pc_r, id_pc_s;
    logic [31:0]     id_word_r, id_word_s;

    // Next-state logic: flush beats stall, stall beats normal flow.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        buf_pc_s   = buf_pc_r;
        buf_word_s = buf_word_r;
        id_valid_s = id_valid_r;
        id_pc_s    = id_pc_r;
        id_word_s  = id_word_r;
        if (Flush) begin
            // A same-cycle ack is ignored; an unacked request is abandoned.
            state_s    = ST_FETCH;
            pc_s       = FlushPC;
            buf_pc_s   = {XLEN{1'b0}};
            buf_word_s = 32'h0000_0000;
            id_valid_s = 1'b0;
            id_pc_s    = {XLEN{1'b0}};
            id_word_s  = 32'h0000_0000;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (IMemAck) begin
                        pc_s = pc_r + PC_STEP;
                        if (Stall) begin
                            buf_pc_s   = pc_r;
                            buf_word_s = IMemRdata;
                            state_s    = ST_HOLD;
                        end else begin
                            id_valid_s = 1'b1;
                            id_pc_s    = pc_r;
                            id_word_s  = IMemRdata;
                        end
                    end else if (!Stall) begin
                        // Bubble: all-zero fields decode as a no-op downstream.
                        id_valid_s = 1'b0;
                        id_pc_s    = {XLEN{1'b0}};
                        id_word_s  = 32'h0000_0000;
                    end else begin
                        id_valid_s = id_valid_r;
                    end
                end
                ST_HOLD: begin
                    if (!Stall) begin
                        id_valid_s = 1'b1;
                        id_pc_s    = buf_pc_r;
                        id_word_s  = buf_word_r;
                        buf_pc_s   = {XLEN{1'b0}};
                        buf_word_s = 32'h0000_0000;
                        state_s    = ST_FETCH;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                default: begin
                    state_s = ST_FETCH;
                end
            endcase
        end
    end

    // State, PC, hold buffer and IF/ID register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_FETCH;
            pc_r       <= RESET_PC;
            buf_pc_r   <= {XLEN{1'b0}};
            buf_word_r <= 32'h0000_0000;
            id_valid_r <= 1'b0;
            id_pc_r    <= {XLEN{1'b0}};
            id_word_r  <= 32'h0000_0000;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            buf_pc_r   <= buf_pc_s;
            buf_word_r <= buf_word_s;
            id_valid_r <= id_valid_s;
            id_pc_r    <= id_pc_s;
            id_word_r  <= id_word_s;
        end
    end

    // Request is suppressed combinationally while reset is asserted.
    assign IMemReq  = (state_r == ST_FETCH) && !RST;
    assign IMemAddr = pc_r;

    // Field outputs are pure wiring off the registered instruction word.
    assign IDValid = id_valid_r;
    assign IDPC    = id_pc_r;
    assign Opecode = id_word_r[31:25];
    assign ALUOp   = id_word_r[14:12];
    assign funct   = id_word_r[6:0];
    assign rd      = id_word_r[11:7];
    assign rs1     = id_word_r[19:15];
    assign rs2     = id_word_r[24:20];
    assign Shamt   = id_word_r[24:20];
    assign ImmI    = {{(XLEN-12){id_word_r[31]}}, id_word_r[31:20]};
    assign ImmS    = {{(XLEN-12){id_word_r[31]}}, id_word_r[31:25], id_word_r[11:7]};

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Testbench for fetch_decode_stage: directed scenarios followed by a
// randomized run checked against a transaction-level model of the stage.
module tb_fetch_decode_stage;

    logic        CLK;
    logic        RST;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic [31:0] IMemRdata;
    logic        IMemAck;
    logic        Stall;
    logic        Flush;
    logic [31:0] FlushPC;
    logic        IDValid;
    logic [31:0] IDPC;
    logic [6:0]  Opecode;
    logic [2:0]  ALUOp;
    logic [6:0]  funct;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] ImmI;
    logic [31:0] ImmS;
    logic [4:0]  Shamt;

    int vectors = 0;
    int errors  = 0;

    fetch_decode_stage dut (
        .CLK(CLK), .RST(RST),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemRdata(IMemRdata), .IMemAck(IMemAck),
        .Stall(Stall), .Flush(Flush), .FlushPC(FlushPC),
        .IDValid(IDValid), .IDPC(IDPC), .Opecode(Opecode), .ALUOp(ALUOp), .funct(funct),
        .rd(rd), .rs1(rs1), .rs2(rs2), .ImmI(ImmI), .ImmS(ImmS), .Shamt(Shamt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- reference model (transaction level) ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    logic [31:0] m_pc;        // address of the next fetch
    ent_t        m_q[$];      // fetched but not yet delivered (at most one)
    logic        m_id_valid;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_word;

    task automatic m_clear_id();
        m_id_valid = 1'b0;
        m_id_pc    = 32'h0;
        m_id_word  = 32'h0;
    endtask

    task automatic m_step(input logic rst, input logic ack, input logic [31:0] word,
                          input logic stall, input logic flush, input logic [31:0] fpc);
        ent_t e;
        if (rst) begin
            m_pc = 32'h0;
            m_q.delete();
            m_clear_id();
        end else if (flush) begin
            m_pc = fpc;
            m_q.delete();
            m_clear_id();
        end else if (m_q.size() != 0) begin
            if (!stall) begin
                e = m_q.pop_front();
                m_id_valid = 1'b1;
                m_id_pc    = e.pc;
                m_id_word  = e.word;
            end
        end else if (ack) begin
            e.pc   = m_pc;
            e.word = word;
            m_pc   = m_pc + 32'd4;
            if (stall) m_q.push_back(e);
            else begin
                m_id_valid = 1'b1;
                m_id_pc    = e.pc;
                m_id_word  = e.word;
            end
        end else if (!stall) begin
            m_clear_id();
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        h = (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
        return {h[15:0], h[31:16]};
    endfunction

    // Apply one cycle of inputs (called at negedge), return at the next negedge.
    task automatic cyc(input logic rst, input logic ack, input logic [31:0] rdata,
                       input logic stall, input logic flush, input logic [31:0] fpc);
        RST = rst; IMemAck = ack; IMemRdata = rdata;
        Stall = stall; Flush = flush; FlushPC = fpc;
        m_step(rst, ack, rdata, stall, flush, fpc);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            vectors++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", IMemReq); end
            vectors++; if (IDValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", IDValid); end
        end
        vectors++; if ({IDPC, Opecode, funct, rd, ImmI} !== 83'h0) begin
            errors++; $display("FAIL reset_fields: got IDPC=%h funct=%h ImmI=%h want 0", IDPC, funct, ImmI); end
        RST = 1'b0;
        #1;
        vectors++; if (IMemReq !== 1'b1) begin errors++; $display("FAIL release_req: got %0b want 1", IMemReq); end
        vectors++; if (IMemAddr !== 32'h0) begin errors++; $display("FAIL release_addr: got %h want 0", IMemAddr); end
    endtask

    task automatic test_streaming();
        cyc(1'b0, 1'b1, 32'h00A3_0293, 1'b0, 1'b0, 32'h0);
        vectors++; if (IDValid !== 1'b1) begin errors++; $display("FAIL stream_valid: got %0b want 1", IDValid); end
        vectors++; if (IDPC !== 32'h0) begin errors++; $display("FAIL stream_idpc: got %h want 0", IDPC); end
        vectors++; if ({funct, ALUOp, rd, rs1} !== {7'h13, 3'd0, 5'd5, 5'd6}) begin
            errors++; $display("FAIL stream_fields: got funct=%h alu=%0d rd=%0d rs1=%0d want 13/0/5/6", funct, ALUOp, rd, rs1); end
        vectors++; if (ImmI !== 32'd10) begin errors++; $display("FAIL stream_immi: got %h want a", ImmI); end
        vectors++; if (IMemAddr !== 32'h4) begin errors++; $display("FAIL stream_next_addr: got %h want 4", IMemAddr); end
        cyc(1'b0, 1'b1, 32'h0040_0313, 1'b0, 1'b0, 32'h0);
        vectors++; if (IDPC !== 32'h4 || IMemAddr !== 32'h8) begin
            errors++; $display("FAIL stream_second: got IDPC=%h addr=%h want 4/8", IDPC, IMemAddr); end
    endtask

    task automatic test_stall();
        cyc(1'b0, 1'b1, 32'h0083_A383, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            vectors++; if (IDPC !== 32'h4 || IDValid !== 1'b1) begin
                errors++; $display("FAIL stall_hold_%0d: got IDPC=%h valid=%0b want 4/1", i, IDPC, IDValid); end
            vectors++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL stall_req_%0d: got %0b want 0", i, IMemReq); end
            if (i < 2) cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        vectors++; if (IDPC !== 32'h8 || IDValid !== 1'b1 || rd !== 5'd7) begin
            errors++; $display("FAIL stall_release: got IDPC=%h valid=%0b rd=%0d want 8/1/7", IDPC, IDValid, rd); end
        vectors++; if (IMemReq !== 1'b1 || IMemAddr !== 32'hC) begin
            errors++; $display("FAIL stall_resume: got req=%0b addr=%h want 1/c", IMemReq, IMemAddr); end
    endtask

    task automatic test_flush();
        // Flush with simultaneous ack and stall: flush wins, word dropped.
        cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h100);
        vectors++; if (IDValid !== 1'b0 || IDPC !== 32'h0 || funct !== 7'h0) begin
            errors++; $display("FAIL flush_kill: got valid=%0b IDPC=%h funct=%h want 0/0/0", IDValid, IDPC, funct); end
        vectors++; if (IMemAddr !== 32'h100 || IMemReq !== 1'b1) begin
            errors++; $display("FAIL flush_addr: got addr=%h req=%0b want 100/1", IMemAddr, IMemReq); end
        cyc(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
        vectors++; if (IDPC !== 32'h100 || IDValid !== 1'b1) begin
            errors++; $display("FAIL flush_target: got IDPC=%h valid=%0b want 100/1", IDPC, IDValid); end
    endtask

    task automatic test_sign_ext();
        cyc(1'b0, 1'b1, 32'hFE11_2E23, 1'b0, 1'b0, 32'h0);
        vectors++; if (ImmS !== 32'hFFFF_FFFC || funct !== 7'h23) begin
            errors++; $display("FAIL sext_imms: got ImmS=%h funct=%h want fffffffc/23", ImmS, funct); end
        cyc(1'b0, 1'b1, 32'h8000_0013, 1'b0, 1'b0, 32'h0);
        vectors++; if (ImmI !== 32'hFFFF_F800) begin errors++; $display("FAIL sext_immi: got %h want fffff800", ImmI); end
    endtask

    task automatic test_wrap_slow();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        vectors++; if (IMemAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr_0: got %h want fffffffc", IMemAddr); end
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            vectors++; if (IMemAddr !== 32'hFFFF_FFFC || IMemReq !== 1'b1 || IDValid !== 1'b0) begin
                errors++; $display("FAIL wrap_wait_%0d: got addr=%h req=%0b valid=%0b want fffffffc/1/0", i, IMemAddr, IMemReq, IDValid); end
        end
        cyc(1'b0, 1'b1, 32'h0010_0093, 1'b0, 1'b0, 32'h0);
        vectors++; if (IDPC !== 32'hFFFF_FFFC || IMemAddr !== 32'h0) begin
            errors++; $display("FAIL wrap_next: got IDPC=%h addr=%h want fffffffc/0", IDPC, IMemAddr); end
    endtask

    // ---------------- randomized run against the model ----------------
    task automatic test_random();
        logic        rst, ack, stall, flush, exp_req;
        logic [31:0] fpc, w;
        logic [75:0] exp_f;
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int n = 0; n < 800; n++) begin
            rst   = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 2) == 0);
            ack   = (m_q.size() == 0) && ($urandom_range(0, 1) == 1);
            fpc   = ($urandom_range(0, 3) == 0) ? $urandom : {$urandom_range(0, 1023), 2'b00};
            w     = mem_word(IMemAddr);
            cyc(rst, ack, w, stall, flush, fpc);
            exp_req = !rst && (m_q.size() == 0);
            exp_f = {m_id_word[31:25], m_id_word[14:12], m_id_word[6:0], m_id_word[11:7],
                     m_id_word[19:15], m_id_word[24:20], m_id_word[24:20],
                     {{20{m_id_word[31]}}, m_id_word[31:20]}};
            vectors++; if (IMemReq !== exp_req) begin errors++; $display("FAIL rnd_req[%0d]: got %0b want %0b", n, IMemReq, exp_req); end
            vectors++; if (IMemAddr !== m_pc) begin errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", n, IMemAddr, m_pc); end
            vectors++; if (IDValid !== m_id_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", n, IDValid, m_id_valid); end
            vectors++; if (IDPC !== m_id_pc) begin errors++; $display("FAIL rnd_idpc[%0d]: got %h want %h", n, IDPC, m_id_pc); end
            vectors++; if ({Opecode, ALUOp, funct, rd, rs1, rs2, Shamt, ImmI} !== exp_f) begin
                errors++; $display("FAIL rnd_fields[%0d]: got %h want %h", n,
                                   {Opecode, ALUOp, funct, rd, rs1, rs2, Shamt, ImmI}, exp_f); end
            vectors++; if (ImmS !== {{20{m_id_word[31]}}, m_id_word[31:25], m_id_word[11:7]}) begin
                errors++; $display("FAIL rnd_imms[%0d]: got %h want %h", n, ImmS,
                                   {{20{m_id_word[31]}}, m_id_word[31:25], m_id_word[11:7]}); end
        end
    endtask

    initial begin
        RST = 1'b1; IMemAck = 1'b0; IMemRdata = 32'h0;
        Stall = 1'b0; Flush = 1'b0; FlushPC = 32'h0;
        m_pc = 32'h0; m_clear_id();
        @(negedge CLK);
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_sign_ext();
        test_wrap_slow();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
